// File: rtl/clkrst.sv
// -----------------------------------------------------------------------------
// clkrst -- cog clock-enable generator and core reset sequencer.
//
// A single clock (clk_cog) runs everything. A 7-bit divider produces a
// one-cycle clock-enable pulse (ena_cog) every 2^(7-clksel_act) cycles. A
// small FSM does four jobs:
//   * holds the core in reset (nres low) for RES_HOLD cycles after any reset
//   * waits SETTLE_CYCLES whenever an oscillator or PLL enable rises
//   * changes the divider select only on a pulse boundary, so that no
//     ena_cog period is ever shortened
//   * performs a software reset when the core sets cfg[7]
//
// Ports
//   clk_cog     in   clock, rising edge
//   res         in   asynchronous active-high reset
//   cfg[7:0]    in   [7] sw reset, [6] PLL en, [5] osc en, [4:3] osc mode
//                    (not used here), [2:0] clock select
//   nres        out  active-low reset to the digital core (registered)
//   ena_cog     out  single-cycle cog clock-enable pulse
//   clksel_act  out  clock select currently applied to the divider
//   settle      out  high while waiting for oscillator/PLL settle
//   dbg_state   out  FSM state (0 HOLD, 1 RUN, 2 SETTLE, 3 SWITCH)
//
// Handshake: there is no valid/ready pair. cfg is a level-sensitive register
// image that is sampled into cfg_q on every edge. All decisions use cfg_q,
// which gives the core one cycle of input latency.
// -----------------------------------------------------------------------------
module clkrst #(
  parameter int RES_HOLD      = 16,
  parameter int SETTLE_CYCLES = 1000
) (
  input  logic       clk_cog,
  input  logic       res,
  input  logic [7:0] cfg,
  output logic       nres,
  output logic       ena_cog,
  output logic [2:0] clksel_act,
  output logic       settle,
  output logic [1:0] dbg_state
);

  typedef enum logic [1:0] {
    ST_HOLD   = 2'd0,
    ST_RUN    = 2'd1,
    ST_SETTLE = 2'd2,
    ST_SWITCH = 2'd3
  } state_t;

  localparam int SET_W = (SETTLE_CYCLES > 2) ? $clog2(SETTLE_CYCLES) : 1;
  localparam logic [15:0]      HOLD_LOAD   = 16'(RES_HOLD - 1);
  localparam logic [SET_W-1:0] SETTLE_LOAD = SET_W'(SETTLE_CYCLES - 1);

  state_t           state_q;
  logic [7:0]       cfg_q;
  logic             nres_q;
  logic             settle_q;
  logic [2:0]       clksel_q;
  logic [6:0]       div_cnt_q;
  logic [15:0]      hold_cnt_q;
  logic [SET_W-1:0] settle_cnt_q;
  logic [1:0]       en_trk_q;     // last seen {pll_en, osc_en}

  logic [6:0] div_m1;
  logic       tick;
  logic       en_rise;
  logic       sw_rst;
  logic       unused_osc_mode;

  // The divisor is 2^(7-sel), so divisor-1 is simply 127 shifted right by sel.
  assign div_m1  = 7'h7F >> clksel_q;
  // The pulse is decoded from registered state only, so an asynchronous
  // reset clears it together with the counter, with no glitch.
  assign tick    = (div_cnt_q == div_m1);
  assign en_rise = |(cfg_q[6:5] & ~en_trk_q);
  assign sw_rst  = cfg_q[7];

  // The oscillator mode bits are carried in cfg_q only for completeness.
  assign unused_osc_mode = ^cfg_q[4:3];

  assign nres       = nres_q;
  assign ena_cog    = tick;
  assign clksel_act = clksel_q;
  assign settle     = settle_q;
  assign dbg_state  = state_q;

  always_ff @(posedge clk_cog or posedge res) begin
    if (res) begin
      state_q      <= ST_HOLD;
      cfg_q        <= 8'h00;
      nres_q       <= 1'b0;
      settle_q     <= 1'b0;
      clksel_q     <= 3'd0;
      div_cnt_q    <= 7'd0;
      hold_cnt_q   <= HOLD_LOAD;
      settle_cnt_q <= '0;
      en_trk_q     <= 2'b00;
    end else begin
      cfg_q <= cfg;

      // The divider free-runs in every state, including HOLD. It wraps on the
      // pulse cycle. A select change is applied only on that same edge, so
      // the next period always starts from zero at the new divisor.
      if (tick) begin
        div_cnt_q <= 7'd0;
      end else begin
        div_cnt_q <= div_cnt_q + 7'd1;
      end

      // A software reset beats everything outside HOLD. Inside HOLD it is
      // ignored, because the core clears cfg while nres is low.
      if (state_q != ST_HOLD && sw_rst) begin
        state_q    <= ST_HOLD;
        nres_q     <= 1'b0;
        settle_q   <= 1'b0;
        clksel_q   <= 3'd0;
        hold_cnt_q <= HOLD_LOAD;
        en_trk_q   <= 2'b00;
      end else begin
        case (state_q)
          ST_HOLD: begin
            nres_q   <= 1'b0;
            settle_q <= 1'b0;
            if (hold_cnt_q == 16'd0) begin
              state_q <= ST_RUN;
              nres_q  <= 1'b1;
            end else begin
              hold_cnt_q <= hold_cnt_q - 16'd1;
            end
          end

          ST_RUN: begin
            // Only rising enables need settling. Tracking follows cfg_q on
            // every cycle, so a dropped enable can be re-armed later.
            en_trk_q <= cfg_q[6:5];
            if (en_rise) begin
              state_q      <= ST_SETTLE;
              settle_q     <= 1'b1;
              settle_cnt_q <= SETTLE_LOAD;
            end else if (cfg_q[2:0] != clksel_q) begin
              state_q <= ST_SWITCH;
            end
          end

          ST_SETTLE: begin
            en_trk_q <= cfg_q[6:5];
            if (en_rise) begin
              // A further enable rising restarts the whole settle wait.
              settle_cnt_q <= SETTLE_LOAD;
            end else if (settle_cnt_q == '0) begin
              state_q  <= ST_SWITCH;
              settle_q <= 1'b0;
            end else begin
              settle_cnt_q <= settle_cnt_q - SET_W'(1);
            end
          end

          ST_SWITCH: begin
            if (cfg_q[2:0] == clksel_q) begin
              state_q <= ST_RUN;
            end else if (tick) begin
              // Take whatever select is sampled on the switching edge.
              clksel_q <= cfg_q[2:0];
              state_q  <= ST_RUN;
            end
          end

          default: begin
            state_q <= ST_HOLD;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_clkrst.sv
// -----------------------------------------------------------------------------
// tb_clkrst -- directed bench for clkrst.
// Cycle counts are numbers of rising edges after the stimulus change. Inputs
// change 1 ns after an edge and outputs are sampled at that same point.
// nres rises on edge 16 after release. The first ena_cog is the cycle that
// follows edge 127, which is the 128th cycle after release.
// -----------------------------------------------------------------------------
module tb_clkrst;

  logic       clk_cog = 1'b0;
  logic       res;
  logic [7:0] cfg;
  logic       nres;
  logic       ena_cog;
  logic [2:0] clksel_act;
  logic       settle;
  logic [1:0] dbg_state;

  int checks = 0;
  int errors = 0;

  localparam logic [1:0] S_HOLD = 2'd0, S_RUN = 2'd1, S_SETTLE = 2'd2, S_SWITCH = 2'd3;

  clkrst #(.RES_HOLD(16), .SETTLE_CYCLES(1000)) dut (
    .clk_cog    (clk_cog),
    .res        (res),
    .cfg        (cfg),
    .nres       (nres),
    .ena_cog    (ena_cog),
    .clksel_act (clksel_act),
    .settle     (settle),
    .dbg_state  (dbg_state)
  );

  // clock / reset
  always #5 clk_cog = ~clk_cog;

  // scoreboard
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  // drivers
  task automatic step();
    @(posedge clk_cog);
    #1;
  endtask

  task automatic edges_to_ena(input int max, output int n);
    n = 0;
    do begin
      step();
      n++;
    end while (!ena_cog && n < max);
  endtask

  task automatic edges_to_settle(input int max, output int n);
    n = 0;
    do begin
      step();
      n++;
    end while (!settle && n < max);
  endtask

  initial begin
    int n;
    int n_nres;
    int n_ena;
    int cnt;
    logic saw;

    // power-up
    res = 1'b1;
    cfg = 8'h00;
    repeat (5) step();
    check("rst_nres", nres, 0);
    check("rst_ena", ena_cog, 0);
    check("rst_sel", clksel_act, 0);
    check("rst_settle", settle, 0);
    check("rst_state", dbg_state, S_HOLD);
    res = 1'b0;

    n = 0; n_nres = -1; n_ena = -1;
    while (n_ena < 0 && n < 300) begin
      step();
      n++;
      if (nres && n_nres < 0) n_nres = n;
      if (ena_cog) n_ena = n;
    end
    check("nres_rise", n_nres, 16);
    check("first_ena", n_ena, 127);
    edges_to_ena(300, n);
    check("period_sel0", n, 128);
    check("sel0", clksel_act, 0);
    check("nres_high", nres, 1);

    // plain switch to sel 7: no period shorter than 128 first
    cfg = 8'h07;
    edges_to_ena(300, n);
    check("sw_no_short", n, 128);
    check("sw_pending_sel", clksel_act, 0);
    check("sw_state", dbg_state, S_SWITCH);
    step();
    check("sw_sel7", clksel_act, 7);
    cnt = 0;
    repeat (8) begin
      if (ena_cog) cnt++;
      step();
    end
    check("sel7_every", cnt, 8);

    // PLL enable with settle
    cfg = 8'h00;
    repeat (5) step();
    check("back_sel0", clksel_act, 0);
    cfg = 8'h66;
    edges_to_settle(10, n);
    check("settle_rise", n, 2);
    check("settle_state", dbg_state, S_SETTLE);
    n = 0;
    while (settle && n < 2000) begin
      step();
      n++;
    end
    check("settle_len", n, 1000);
    check("post_settle_state", dbg_state, S_SWITCH);
    n = 0;
    while (clksel_act != 3'd6 && n < 300) begin
      step();
      n++;
    end
    check("pll_sel6", clksel_act, 6);
    check("p2_0", ena_cog, 0);
    step(); check("p2_1", ena_cog, 1);
    step(); check("p2_2", ena_cog, 0);
    step(); check("p2_3", ena_cog, 1);

    // enable drop: no settle, direct switch to period 4
    cfg = 8'h05;
    n = 0; saw = 1'b0;
    while (clksel_act != 3'd5 && n < 50) begin
      step();
      n++;
      if (settle) saw = 1'b1;
    end
    check("drop_no_settle", saw, 0);
    check("drop_sel5", clksel_act, 5);
    edges_to_ena(50, n);
    check("p4_first", n, 3);
    edges_to_ena(50, n);
    check("p4", n, 4);

    // re-raise, then a software reset in the middle of the settle wait
    cfg = 8'h66;
    edges_to_settle(10, n);
    check("resettle_rise", n, 2);
    repeat (500) step();
    check("resettle_mid", settle, 1);
    check("resettle_state", dbg_state, S_SETTLE);
    cfg = 8'h87;
    n = 0;
    while (nres && n < 10) begin
      step();
      n++;
    end
    check("swrst_nres", n, 2);
    check("swrst_settle", settle, 0);
    check("swrst_sel", clksel_act, 0);
    check("swrst_state", dbg_state, S_HOLD);
    cfg = 8'h00;
    n = 0;
    while (!nres && n < 100) begin
      step();
      n++;
    end
    check("swrst_hold", n, 16);
    check("swrst_run", dbg_state, S_RUN);

    // asynchronous reset while a switch is pending
    edges_to_ena(200, n);
    cfg = 8'h01;
    repeat (4) step();
    check("pend_state", dbg_state, S_SWITCH);
    #2 res = 1'b1;
    #1;
    check("ares_ena", ena_cog, 0);
    check("ares_nres", nres, 0);
    check("ares_sel", clksel_act, 0);
    check("ares_state", dbg_state, S_HOLD);
    step();
    res = 1'b0;
    cfg = 8'h00;
    edges_to_ena(300, n);
    check("ares_first_ena", n, 127);
    check("ares_sel_kept", clksel_act, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/clkrst.md
CLKRST -- requirements
Module: clkrst

Interface
REQ-001 SHALL have parameter RES_HOLD, default 16, number of clk_cog cycles nres is held low after any reset source.
REQ-002 SHALL have parameter SETTLE_CYCLES, default 1000, number of clk_cog cycles waited after an oscillator/PLL enable rises.
REQ-003 SHALL have port clk_cog  input  1  the single clock; all state is on its rising edge.
REQ-004 SHALL have port res  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port cfg  input  8  clock configuration register from the digital core: [7] software reset, [6] PLL enable, [5] oscillator enable, [4:3] oscillator mode (ignored), [2:0] clock select.
REQ-006 SHALL have port nres  output  1  active-low reset to the digital core.
REQ-007 SHALL have port ena_cog  output  1  single-cycle cog clock-enable pulse.
REQ-008 SHALL have port clksel_act  output  3  clock select currently applied to the divider.
REQ-009 SHALL have port settle  output  1  high while waiting for oscillator/PLL settle.

Function
REQ-010 SHALL register cfg into cfg_q every cycle; all decisions use cfg_q (1-cycle input latency).
REQ-011 SHALL divide by 2^(7-clksel_act): sel 7 -> ena_cog every cycle; sel 0 -> one pulse per 128 cycles.
REQ-012 SHALL use a 7-bit divider counter: ena_cog=1 when counter == divisor-1, counter then wraps to 0; otherwise increments.
REQ-013 SHALL implement states HOLD, RUN, SETTLE, SWITCH.
REQ-014 HOLD: nres=0; 16-bit hold counter counts down from RES_HOLD-1; at 0 -> RUN with nres=1 on the next cycle.
REQ-015 RUN: cfg_q[7]=1 -> HOLD (reload hold counter, clksel_act<=0, enable tracking cleared).
REQ-016 RUN: a bit of cfg_q[6:5] that is 1 while its tracked copy is 0 -> SETTLE (load settle counter SETTLE_CYCLES-1, update tracked copy).
REQ-017 RUN: otherwise cfg_q[2:0] != clksel_act -> SWITCH; tracked copy of cfg_q[6:5] follows cfg_q every RUN cycle (falling enables need no settle).
REQ-018 SETTLE: settle=1; counts down to 0, then -> SWITCH; a new enable rise restarts the count; cfg_q[7]=1 aborts to HOLD.
REQ-019 SWITCH: waits for a cycle with ena_cog=1, loads clksel_act<=cfg_q[2:0] and counter<=0 on that edge, -> RUN; if cfg_q[2:0]==clksel_act on entry, -> RUN without change.
REQ-020 SHALL never shorten an ena_cog period: the first period after a switch is exactly the new divisor.
REQ-021 cfg_q[7]=1 SHALL have priority over every other event in every state except HOLD.
REQ-022 In HOLD, cfg_q[7]=1 SHALL be ignored (the core's cfg clears while nres=0).
REQ-023 ena_cog SHALL keep running in HOLD at the current clksel_act.
REQ-024 A cfg_q[2:0] change during SWITCH SHALL take the value sampled on the switching edge.

Reset
REQ-025 res=1 SHALL asynchronously force: state HOLD, nres=0, ena_cog=0, clksel_act=0, settle=0, divider counter=0, hold counter=RES_HOLD-1, settle counter=0, cfg_q=0, enable tracking=0.
REQ-026 After res deasserts, nres SHALL rise exactly RES_HOLD cycles later; the first ena_cog SHALL occur 128 cycles after deassertion.
REQ-027 res asserted mid-SETTLE or mid-SWITCH SHALL discard the pending operation with no ena_cog glitch.

Verification
REQ-028 Power-up: res high 5 cycles, release, cfg=0x00 -> nres low 16 cycles then high; ena_cog period 128; clksel_act=0.
REQ-029 Plain switch: cfg=0x07 in RUN -> clksel_act=7 on the edge of the next pending ena_cog pulse, then ena_cog every cycle; no period under 128 before it.
REQ-030 PLL enable: SETTLE_CYCLES=1000, cfg 0x00 -> 0x66 -> settle high 1000 cycles, then clksel_act=6 at the next pulse boundary, period 2.
REQ-031 Software reset: cfg=0x87 during SETTLE -> HOLD, nres low 16 cycles, clksel_act=0, settle=0.
REQ-032 Enable drop: from cfg=0x66 running, cfg=0x05 -> no settle, direct SWITCH, period 4; re-raising to 0x66 -> settle again for 1000 cycles.
